// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the shared-ALU controller.
package alu_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/compare datapath built on a single ripple adder.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] f,
  output logic             overflow
);

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] sum;
  logic             c;
  logic             c_msb_in;
  logic             c_out;
  logic             arith_ovf;

  // Subtract and both compares reuse the adder as x + ~y + 1.
  always_comb begin
    y_eff    = (op == OP_ADD) ? y : ~y;
    c        = (op != OP_ADD);
    sum      = '0;
    c_msb_in = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = x[i] ^ y_eff[i] ^ c;
      if (i == WIDTH - 1) begin
        c_msb_in = c;
      end
      c = (x[i] & y_eff[i]) | (c & (x[i] ^ y_eff[i]));
    end
    c_out = c;
  end

  assign arith_ovf = c_msb_in ^ c_out;

  always_comb begin
    f        = '0;
    overflow = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        f        = sum;
        overflow = arith_ovf;
      end
      OP_SLT:  f[0] = sum[WIDTH-1] ^ arith_ovf;
      OP_SLTU: f[0] = ~c_out;
      default: f    = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and 3-state sequencer sharing one alu_core among NREQ requesters.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_x,
  input  logic [WIDTH*NREQ-1:0] req_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [WIDTH-1:0]      rsp_f,
  output logic                  rsp_overflow
);

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  op_t              op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [IW-1:0]    id_q;
  logic [WIDTH-1:0] f_q;
  logic             ovf_q;
  logic [IW-1:0]    rsp_id_q;

  logic             gnt_found;
  logic [IW-1:0]    gnt_idx;
  int unsigned      cand;
  logic             accept;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_x, sel_y;
  logic [WIDTH-1:0] core_f;
  logic             core_ovf;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_x  = '0;
    sel_y  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_x  = req_x[WIDTH*i +: WIDTH];
        sel_y  = req_y[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_d            = ST_BUSY;
          rr_ptr_d           = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_BUSY: state_d = ST_DONE;
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .op      (op_q),
    .x       (x_q),
    .y       (y_q),
    .f       (core_f),
    .overflow(core_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      op_q     <= OP_ADD;
      x_q      <= '0;
      y_q      <= '0;
      id_q     <= '0;
      f_q      <= '0;
      ovf_q    <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        op_q <= op_t'(sel_op);
        x_q  <= sel_x;
        y_q  <= sel_y;
        id_q <= gnt_idx;
      end
      if (state_q == ST_BUSY) begin
        f_q      <= core_f;
        ovf_q    <= core_ovf;
        rsp_id_q <= id_q;
      end
    end
  end

  assign rsp_valid    = (state_q == ST_DONE);
  assign rsp_id       = rsp_id_q;
  assign rsp_f        = f_q;
  assign rsp_overflow = ovf_q;

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing and arbitration controller that shares one 32-bit add/sub/compare datapath among several requesters. Each requester presents an opcode and two operands over a valid/ready handshake. A round-robin arbiter grants one request at a time, and the controller latches the operands and runs them through a single `alu_core` instance. It then holds the registered result and overflow flag on a response handshake until the consumer accepts them. It sits between the instruction-issue side and the shared 32-bit ALU.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_op  in  2*NREQ  opcode per requester; slice i = bits [2i+1:2i]
- req_x  in  WIDTH*NREQ  operand x per requester; slice i = bits [WIDTH*(i+1)-1 : WIDTH*i]
- req_y  in  WIDTH*NREQ  operand y per requester; same slicing as req_x
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  clog2(NREQ)  index of the requester that owns the result
- rsp_f  out  WIDTH  result
- rsp_overflow  out  1  signed overflow flag

## Operation
- Opcodes: 00 ADD (x+y), 01 SUB (x+~y+1), 10 SLT (signed x<y), 11 SLTU (unsigned x<y).
- Overflow flag:
  - ADD/SUB: carry into the MSB XOR carry out of the MSB.
  - SLT/SLTU: always 0.
- Compare results:
  - SLT: f = {WIDTH-1 zeros, diff[MSB] XOR sub_overflow}.
  - SLTU: f = {zeros, NOT carry_out of the subtract}.
- All arithmetic is modulo 2^WIDTH and carry-in of the base add is 0. The subtract uses a single adder pass with carry-in 1; there is no separate +1 adder stage.
- State machine, with states IDLE, BUSY, DONE:
  - IDLE: the arbiter picks the first i with req_valid[i]=1, searching from the priority pointer rr_ptr upward with wrap. It drives req_ready[i]=1 combinationally, for that i only. On that edge the controller latches op/x/y/id, advances rr_ptr to (i+1) mod NREQ, and moves to BUSY. If no request is valid it stays in IDLE and rr_ptr is unchanged.
  - BUSY: alu_core evaluates the latched operands. At the end of the cycle rsp_f/rsp_overflow/rsp_id are registered and the state moves to DONE.
  - DONE: rsp_valid=1 and the outputs are held stable. When rsp_ready=1 the controller returns to IDLE. There is no new grant in the same cycle.
- req_ready is all zeros in BUSY and DONE.
- Requesters must hold valid/op/x/y until accepted. A drop before acceptance is legal and ignored.
- Reset, which may arrive at any time including mid-operation:
  - state returns to IDLE and rr_ptr to 0;
  - the in-flight operation is discarded with no response.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_f=0, rsp_overflow=0.

## Timing
- Accept edge T (req_valid[i] & req_ready[i]) → BUSY during T+1 → rsp_valid=1 from edge T+2.
- Minimum issue interval is 3 cycles: accept, BUSY, DONE with rsp_ready=1, then IDLE.
- rsp_ready held high in DONE → rsp_valid falls at the next edge, and the next grant is possible on the following edge.
- Backpressure: with rsp_ready=0, DONE persists indefinitely and rsp_* stay unchanged.
- If all NREQ requesters are continuously valid, they are granted in order rr_ptr, rr_ptr+1, … with wrap. There is no starvation: every requester is served within NREQ operations.
- req_ready depends combinationally on req_valid and state. rsp_* are purely registered.

## Structure
- Package `alu_pkg`:
  - op encoding enum (OP_ADD, OP_SUB, OP_SLT, OP_SLTU);
  - OP_W=2;
  - state enum (ST_IDLE, ST_BUSY, ST_DONE).
- Sub-module `alu_core`: combinational, WIDTH-parameterized.
  - Inputs: op, x, y. Outputs: f, overflow.
  - One ripple adder with conditional inversion of y and carry-in = (op≠ADD). It exposes the MSB carry-in and carry-out internally.
- The top level contains only the arbiter, rr_ptr, the FSM, the operand latches and the result registers.

## Test plan
- Single SUB, requester 0, x=9, y=19 → rsp_f=0xFFFFFFF6, rsp_overflow=0, rsp_id=0, rsp_valid at accept+2.
- SLT, requester 2, x=14507, y=97400 → rsp_f=1. SLTU with x=0xFFFFFFFF, y=1 → rsp_f=0. SLT with the same operands → rsp_f=1.
- ADD x=0x7FFFFFFF, y=1 → rsp_f=0x80000000, rsp_overflow=1. SUB x=0x80000000, y=1 → rsp_f=0x7FFFFFFF, rsp_overflow=1.
- All four requesters held valid with rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1. req_ready one-hot on accept cycles only; ops issued every 3 cycles.
- rsp_ready=0 for 5 cycles in DONE → rsp_valid and rsp_f stable, req_ready=0 throughout. Release → IDLE, then the next grant.
- Assert rst_n=0 during BUSY → all outputs 0 immediately. After release, no stale response appears and the first grant goes to the lowest valid index (rr_ptr=0).
